// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//
// Run-time programmable clock divider. Produces a registered divided clock
// (clk_out) and a one-cycle strobe (tick) on each rising edge of clk_out.
// Ratio changes and start/stop requests only take effect on whole-period
// boundaries, so clk_out never shows a runt or stretched pulse.
//
// Parameters
//   CNT_W        width of the ratio and the period counter
//   DEFAULT_DIV  ratio loaded at reset (2 .. 2^CNT_W-1)
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high
//   en          in   run request (level)
//   div_req     in   ratio-change request (level, held until div_ack)
//   div_val     in   requested ratio, sampled on accept
//   div_ack     out  one-cycle pulse when a request completes
//   div_err     out  one-cycle pulse with div_ack when the request was rejected
//   busy        out  a legal request is accepted and waiting for a boundary
//   cur_div     out  ratio currently in effect
//   clk_out     out  divided clock (registered)
//   tick        out  high in the first cycle of every period
//   running     out  high in RUN or STOPPING
//   period_cnt  out  16-bit tick counter, only when CLK_DIV_CTRL_PERIOD_CNT_EN
//                    is defined
//
// Optional feature macro: CLK_DIV_CTRL_PERIOD_CNT_EN
//
// State table
//   state        | meaning
//   ST_STOPPED   | clk_out low, counter held at 0
//   ST_RUN       | counting periods, en still asserted
//   ST_STOPPING  | en dropped, finishing the current period
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div,
    output logic             clk_out,
    output logic             tick,
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    output logic [15:0]      period_cnt,
`endif
    output logic             running
);

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic             at_end;
    logic             accept;
    logic             legal;
    logic             active_d;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_STOPPED;
            cnt_q     <= '0;
            cur_div_q <= CNT_W'(DEFAULT_DIV);
            pend_q    <= '0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        pend_d    = pend_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;

        at_end = (cnt_q == (cur_div_q - CNT_W'(1)));
        // The ack cycle is not an accept cycle: a requester still holding
        // div_req while it sees div_ack is treated as a fresh request only
        // in the following cycle.
        accept = div_req && !busy_q && !ack_q;
        legal  = (div_val > CNT_W'(1));

        case (state_q)
            ST_STOPPED: begin
                cnt_d = '0;
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
                if (!en) begin
                    // Dropping en on the last cycle of a period already
                    // finishes that period.
                    state_d = at_end ? ST_STOPPED : ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
                if (en) begin
                    state_d = ST_RUN;
                end else if (at_end) begin
                    state_d = ST_STOPPED;
                end
            end
            default: begin
                state_d = ST_STOPPED;
                cnt_d   = '0;
            end
        endcase

        // A pending ratio is applied on the period boundary; a stop on the
        // same boundary still gets its ack. The STOPPED arm only guards
        // against a pending value left over without a boundary.
        if (busy_q && ((state_q == ST_STOPPED) || at_end)) begin
            cur_div_d = pend_q;
            busy_d    = 1'b0;
            ack_d     = 1'b1;
        end else if (accept) begin
            if (!legal) begin
                ack_d = 1'b1;
                err_d = 1'b1;
            end else if (state_q == ST_STOPPED) begin
                // No period in flight: the new ratio can take effect now.
                cur_div_d = div_val;
                ack_d     = 1'b1;
            end else begin
                pend_d = div_val;
                busy_d = 1'b1;
            end
        end

        // Outputs are registered, so they are derived from the values the
        // counter and ratio will hold in the next cycle.
        active_d  = (state_d != ST_STOPPED);
        clk_out_d = active_d && (cnt_d < (cur_div_d >> 1));
        tick_d    = active_d && (cnt_d == '0);
    end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    // Counts periods started; wraps naturally at 16 bits. tick never
    // asserts in STOPPED, so the count holds there.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= 16'd0;
        end else if (tick_q) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`endif

    assign div_ack = ack_q;
    assign div_err = err_q;
    assign busy    = busy_q;
    assign cur_div = cur_div_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign running = (state_q != ST_STOPPED);

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time programmable clock-divider controller. It generates a divided clock (clk_out) plus a one-cycle rising-edge strobe (tick) from the system clock. Divide-ratio changes and start/stop requests are sequenced so they take effect only on whole-period boundaries, so clk_out never shows a runt or stretched pulse. It sits between the register/config logic and every consumer of a divided clock or clock enable.

Parameters:
- CNT_W, 8: width of the divide ratio and of the internal period counter.
- DEFAULT_DIV, 4: ratio loaded at reset. Legal range is 2..2^CNT_W-1.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: run request (level).
- div_req, input, 1: ratio-change request (level).
- div_val, input, CNT_W: requested ratio N; sampled on accept.
- div_ack, output, 1: one-cycle pulse when a request completes.
- div_err, output, 1: one-cycle pulse, coincident with div_ack, when the request was rejected.
- busy, output, 1: a request is accepted and pending.
- cur_div, output, CNT_W: ratio currently in effect.
- clk_out, output, 1: divided clock (registered).
- tick, output, 1: one-cycle pulse on each cycle where clk_out goes 0->1.
- running, output, 1: high in state RUN or STOPPING.

Behaviour:
- Reset values:
  - clk_out=0, tick=0, div_ack=0, div_err=0, busy=0, running=0.
  - cur_div=DEFAULT_DIV, counter=0, state=STOPPED.
  - Any pending request is discarded with no ack.
- Waveform for ratio N:
  - Period is N clk cycles; counter runs 0..N-1.
  - clk_out=1 while counter < floor(N/2), otherwise 0. Example: N=3 gives 1 high, 2 low; N=4 gives 2 high, 2 low.
  - tick=1 in the counter==0 cycle of every period.
- State STOPPED:
  - clk_out=0, counter held at 0.
  - en=1 sampled in cycle k: go to RUN; cycle k+1 is counter=0 with clk_out=1 and tick=1.
- State RUN:
  - Counter increments each cycle and wraps N-1 -> 0.
  - en=0 sampled: go to STOPPING.
- State STOPPING:
  - Finishes the current period. At counter==N-1, next cycle is STOPPED with clk_out=0.
  - en=1 re-sampled before the boundary returns to RUN with no gap.
- Request acceptance:
  - A request is accepted when div_req=1 and busy=0.
  - Legal value (2..2^CNT_W-1): latch it as pending; busy=1 from the next cycle.
  - Illegal value (0 or 1): the next cycle pulses div_ack=1 and div_err=1; busy never sets; cur_div is unchanged.
- Requests while busy are ignored; the requester holds div_req until it sees div_ack.
- Applying a pending ratio:
  - Running: applied at the cycle where counter==N-1. The next cycle starts the new period with cur_div=new value, counter=0, div_ack=1, busy=0.
  - STOPPED: applied the cycle after acceptance, with div_ack=1 and busy=0.
- Simultaneous events:
  - Pending ratio and stop at the same boundary: both take effect; ack is issued and the state goes to STOPPED.
  - div_req held high after div_ack: treated as a new request in the cycle after the ack.
- Arithmetic: counter is CNT_W bits; floor(N/2) is a right-shift of cur_div. No other widening.
- Reset mid-operation: asserting reset in any state or phase forces all reset values in the next cycle. No ack is issued for a pending request.

Optional Feature:
- Macro: CLK_DIV_CTRL_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt (16 bits), reset to 0.
  - Increments on every tick and wraps 0xFFFF -> 0.
  - Holds its value in STOPPED.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then en=1 with DEFAULT_DIV=4: clk_out pattern 1100 repeats; tick every 4 cycles; first tick 1 cycle after en is sampled.
- While running N=4, request div_val=3 mid-period: busy=1 until the N=4 period ends; div_ack in the first cycle of the new period; then pattern 100 repeats and cur_div=3.
- Request div_val=1: div_ack and div_err pulse together 1 cycle after acceptance; busy stays 0; cur_div and clk_out pattern unchanged.
- Drop en at counter=1 with N=6: the current 111000 period completes, then clk_out=0, running=0; no partial pulse.
- In STOPPED, request div_val=10: div_ack 1 cycle after acceptance and cur_div=10; en=1 then gives 5 high, 5 low.
- Assert reset 2 cycles after accepting div_val=8 while running: all outputs return to reset values, no div_ack, cur_div=4. With the macro defined, period_cnt is 0 after reset and counts ticks afterwards.
